// File: rtl/cpu_bus_scheduler.sv
// cpu_bus_scheduler
//   Serializes CPU bus traffic between the IM fetch master (M0) and the DM
//   load/store master (M1). Only one AXI transaction is in flight at a time.
//   A wrapper may raise its AR/AW valid only while it holds the grant.
//   DM normally wins arbitration. IM is protected by a starvation counter.
//   A DM write to the same slave region as a pending IM read goes first, so
//   the read observes the write (read-after-write ordering).
// Ports
//   ACLK, ARESETn               clock (rising edge), async active-low reset
//   im_req / im_addr            IM read request and its address
//   im_ar_hs, im_rlast_hs       M0 AR handshake, M0 last-beat R handshake
//   dm_rreq / dm_wreq / dm_addr DM read/write request and its address
//   dm_ar_hs, dm_aw_hs          M1 AR / AW handshakes
//   dm_rlast_hs, dm_b_hs        M1 last-beat R handshake, M1 B handshake
//   im_gnt, dm_gnt              registered grants
//   dm_is_write                 direction of the current/last DM grant
//   busy                        a transaction is in flight
module cpu_bus_scheduler #(
   parameter int ADDR_W     = 32,
   parameter int REGION_LSB = 16,
   parameter int MAX_WAIT   = 4
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              im_req,
   input  logic [ADDR_W-1:0] im_addr,
   input  logic              im_ar_hs,
   input  logic              im_rlast_hs,
   input  logic              dm_rreq,
   input  logic              dm_wreq,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic              dm_ar_hs,
   input  logic              dm_aw_hs,
   input  logic              dm_rlast_hs,
   input  logic              dm_b_hs,
   output logic              im_gnt,
   output logic              dm_gnt,
   output logic              dm_is_write,
   output logic              busy
);

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   typedef enum logic [2:0] {
      IDLE, IM_AR, IM_R, DM_AR, DM_R, DM_AW, DM_B
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic       dm_wr_q, dm_wr_d;
   logic       same_region;
   logic       dm_pick;

   assign same_region = (im_addr[ADDR_W-1:REGION_LSB] == dm_addr[ADDR_W-1:REGION_LSB]);

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      dm_wr_d    = dm_wr_q;
      dm_pick    = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Same-region write goes ahead of the IM read even when IM is
            // starved; the counter stays saturated so IM wins next time.
            if (dm_wreq && im_req && same_region) begin
               state_d = DM_AW;
               dm_wr_d = 1'b1;
               dm_pick = 1'b1;
            end else if (im_req && (wait_cnt_q == MAX_WAIT_C)) begin
               state_d    = IM_AR;
               wait_cnt_d = 4'd0;
            end else if (dm_wreq) begin
               state_d = DM_AW;
               dm_wr_d = 1'b1;
               dm_pick = 1'b1;
            end else if (dm_rreq) begin
               state_d = DM_AR;
               dm_wr_d = 1'b0;
               dm_pick = 1'b1;
            end else if (im_req) begin
               state_d    = IM_AR;
               wait_cnt_d = 4'd0;
            end
            // Count DM wins only while IM is actually waiting.
            if (dm_pick && im_req)
               wait_cnt_d = (wait_cnt_q >= MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt_q + 4'd1;
         end
         IM_AR: if (im_ar_hs)    state_d = IM_R;
         IM_R:  if (im_rlast_hs) state_d = IDLE;
         DM_AR: if (dm_ar_hs)    state_d = DM_R;
         DM_R:  if (dm_rlast_hs) state_d = IDLE;
         DM_AW: if (dm_aw_hs)    state_d = DM_B;
         DM_B:  if (dm_b_hs)     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q     <= IDLE;
         wait_cnt_q  <= 4'd0;
         dm_wr_q     <= 1'b0;
         im_gnt      <= 1'b0;
         dm_gnt      <= 1'b0;
         dm_is_write <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         dm_wr_q     <= dm_wr_d;
         im_gnt      <= (state_d == IM_AR);
         dm_gnt      <= (state_d == DM_AR) || (state_d == DM_AW);
         dm_is_write <= dm_wr_d;
         busy        <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_cpu_bus_scheduler.sv
// Scoreboard bench for cpu_bus_scheduler: stimulus pushes the expected
// grant sequence, a negedge monitor pops and compares on each new grant.
module tb_cpu_bus_scheduler;

   localparam int ADDR_W = 32;

   logic              ACLK = 1'b0;
   logic              ARESETn = 1'b0;
   logic              im_req = 1'b0;
   logic [ADDR_W-1:0] im_addr = '0;
   logic              im_ar_hs = 1'b0;
   logic              im_rlast_hs = 1'b0;
   logic              dm_rreq = 1'b0;
   logic              dm_wreq = 1'b0;
   logic [ADDR_W-1:0] dm_addr = '0;
   logic              dm_ar_hs = 1'b0;
   logic              dm_aw_hs = 1'b0;
   logic              dm_rlast_hs = 1'b0;
   logic              dm_b_hs = 1'b0;
   logic              im_gnt, dm_gnt, dm_is_write, busy;

   cpu_bus_scheduler #(.ADDR_W(ADDR_W), .REGION_LSB(16), .MAX_WAIT(4)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .im_req(im_req), .im_addr(im_addr), .im_ar_hs(im_ar_hs), .im_rlast_hs(im_rlast_hs),
      .dm_rreq(dm_rreq), .dm_wreq(dm_wreq), .dm_addr(dm_addr),
      .dm_ar_hs(dm_ar_hs), .dm_aw_hs(dm_aw_hs), .dm_rlast_hs(dm_rlast_hs), .dm_b_hs(dm_b_hs),
      .im_gnt(im_gnt), .dm_gnt(dm_gnt), .dm_is_write(dm_is_write), .busy(busy)
   );

   always #5 ACLK = ~ACLK;

   // {im_gnt, dm_gnt, dm_is_write} expected at the first cycle of a grant
   typedef struct packed {logic im; logic dm; logic wr;} gnt_t;

   gnt_t exp_q[$];
   gnt_t mon_e;
   int   tests = 0;
   int   fails = 0;
   logic exp_wr = 1'b0;
   logic prev_g = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_im();
      exp_q.push_back({1'b1, 1'b0, exp_wr});
   endtask

   task automatic push_dm(input logic wr);
      exp_wr = wr;
      exp_q.push_back({1'b0, 1'b1, wr});
   endtask

   // Monitor: compare each newly raised grant against the scoreboard head.
   always @(negedge ACLK) begin
      if (ARESETn && (im_gnt || dm_gnt) && !prev_g) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_grant: got %b%b%b expected none", im_gnt, dm_gnt, dm_is_write);
         end else begin
            mon_e = exp_q.pop_front();
            chk("grant{im,dm,wr}", {29'd0, im_gnt, dm_gnt, dm_is_write}, {29'd0, mon_e});
         end
      end
      prev_g = im_gnt || dm_gnt;
   end

   task automatic wait_gnt(output bit ok);
      int n = 0;
      while (!(im_gnt || dm_gnt) && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      ok = im_gnt || dm_gnt;
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL grant_timeout: got no grant expected a grant within 20 cycles at %0t", $time);
      end
   endtask

   // Complete whichever transaction is granted; returns on the negedge
   // after the scheduler is back in IDLE, so inputs set next are arbitrated.
   task automatic serve(input bit keep_im, input bit keep_dm);
      bit ok;
      wait_gnt(ok);
      if (ok) begin
         if (im_gnt) begin
            im_ar_hs = 1'b1;
            if (!keep_im) im_req = 1'b0;
            @(negedge ACLK);
            im_ar_hs = 1'b0; im_rlast_hs = 1'b1;
            @(negedge ACLK);
            im_rlast_hs = 1'b0;
         end else if (!dm_is_write) begin
            dm_ar_hs = 1'b1;
            if (!keep_dm) dm_rreq = 1'b0;
            @(negedge ACLK);
            dm_ar_hs = 1'b0; dm_rlast_hs = 1'b1;
            @(negedge ACLK);
            dm_rlast_hs = 1'b0;
         end else begin
            dm_aw_hs = 1'b1;
            if (!keep_dm) dm_wreq = 1'b0;
            @(negedge ACLK);
            dm_aw_hs = 1'b0; dm_b_hs = 1'b1;
            @(negedge ACLK);
            dm_b_hs = 1'b0;
         end
      end
   endtask

   initial begin
      bit ok;
      // T1: reset state, then a lone IM fetch
      im_req = 1'b1; im_addr = 32'h0000_0000;
      repeat (2) @(negedge ACLK);
      chk("reset_im_gnt", {31'd0, im_gnt}, 0);
      chk("reset_dm_gnt", {31'd0, dm_gnt}, 0);
      chk("reset_busy", {31'd0, busy}, 0);
      chk("reset_dm_is_write", {31'd0, dm_is_write}, 0);
      push_im();
      ARESETn = 1'b1;
      serve(0, 0);
      chk("busy_after_im", {31'd0, busy}, 0);

      // T2: IM and DM read together -> DM first, then IM
      im_req = 1'b1; dm_rreq = 1'b1; dm_addr = 32'h0002_0000;
      push_dm(0); push_im();
      serve(1, 0);
      serve(0, 0);

      // T3: DM reads back-to-back starve IM for exactly 4 grants
      im_req = 1'b1; dm_rreq = 1'b1;
      repeat (4) push_dm(0);
      push_im(); push_dm(0);
      repeat (4) serve(1, 1);
      serve(0, 1);
      serve(0, 0);

      // T4: saturated counter, same-region write still goes first
      im_req = 1'b1; im_addr = 32'h0001_0000; dm_addr = 32'h0002_0000;
      for (int i = 0; i < 4; i++) begin
         dm_rreq = 1'b1; push_dm(0);
         serve(1, 0);
      end
      dm_wreq = 1'b1; dm_addr = 32'h0001_0040;
      push_dm(1); push_im();
      serve(1, 0);
      serve(0, 0);

      // T5: saturated counter, different-region write -> IM first
      im_req = 1'b1; im_addr = 32'h0000_0000; dm_addr = 32'h0001_0040;
      for (int i = 0; i < 4; i++) begin
         dm_rreq = 1'b1; push_dm(0);
         serve(1, 0);
      end
      dm_wreq = 1'b1;
      push_im(); push_dm(1);
      serve(0, 0);
      serve(0, 0);

      // T6: reset asserted while in DM_B
      im_req = 1'b1; im_addr = 32'h0000_0000;
      dm_wreq = 1'b1; dm_addr = 32'h0002_0000;
      push_dm(1);
      wait_gnt(ok);
      dm_aw_hs = 1'b1; dm_wreq = 1'b0;
      @(negedge ACLK);
      dm_aw_hs = 1'b0;
      chk("busy_in_dm_b", {31'd0, busy}, 1);
      chk("dm_gnt_in_dm_b", {31'd0, dm_gnt}, 0);
      ARESETn = 1'b0;
      #1;
      chk("midreset_im_gnt", {31'd0, im_gnt}, 0);
      chk("midreset_dm_gnt", {31'd0, dm_gnt}, 0);
      chk("midreset_busy", {31'd0, busy}, 0);
      chk("midreset_dm_is_write", {31'd0, dm_is_write}, 0);
      exp_wr = 1'b0;
      dm_rreq = 1'b1;
      @(negedge ACLK);
      ARESETn = 1'b1;
      // a cleared counter means IM waits a full 4 DM grants again
      repeat (4) push_dm(0);
      push_im(); push_dm(0);
      repeat (4) serve(1, 1);
      serve(0, 1);
      serve(0, 0);

      // T7: stray dm_b_hs while in IM_R is ignored
      im_req = 1'b1;
      push_im();
      wait_gnt(ok);
      im_ar_hs = 1'b1; im_req = 1'b0;
      @(negedge ACLK);
      im_ar_hs = 1'b0; dm_b_hs = 1'b1;
      @(negedge ACLK);
      dm_b_hs = 1'b0;
      chk("stray_busy", {31'd0, busy}, 1);
      chk("stray_im_gnt", {31'd0, im_gnt}, 0);
      @(negedge ACLK);
      chk("stray_still_im_r", {31'd0, busy}, 1);
      im_rlast_hs = 1'b1;
      @(negedge ACLK);
      im_rlast_hs = 1'b0;
      chk("busy_after_stray", {31'd0, busy}, 0);
      im_req = 1'b1; dm_rreq = 1'b1;
      repeat (4) push_dm(0);
      push_im(); push_dm(0);
      repeat (4) serve(1, 1);
      serve(0, 1);
      serve(0, 0);

      repeat (3) @(negedge ACLK);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
